ppg_window_stats: RTL and testbench
===================================

PPG_WINDOW_STATS -- requirements
Module: ppg_window_stats

Interface
REQ-001 The block SHALL have parameter WINDOW, default 100, meaning the number of IR samples per statistics window (range 2..1023).
REQ-002 The block SHALL have parameter HYST, default 8, meaning the beat-detector hysteresis in ADC codes.
REQ-003 Port CLK  input  1  system clock; all logic on posedge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port Enable  input  1  tracks the LED-controller "settings found" flag; 1 means process samples.
REQ-006 Port LED_RED  input  1  red-LED phase indicator from the LED controller.
REQ-007 Port LED_IR  input  1  IR-LED phase indicator from the LED controller.
REQ-008 Port RED_ADC_Value  input  8  latest red sample, held by the controller.
REQ-009 Port IR_ADC_Value  input  8  latest IR sample, held by the controller.
REQ-010 Ports RED_AC, RED_DC, IR_AC, IR_DC  output  8 each  registered window statistics.
REQ-011 Port Stats_Valid  output  1  one-cycle pulse: new statistics are present.
REQ-012 Port Beat  output  1  one-cycle pulse: IR rising threshold crossing.
REQ-013 Port Beat_Interval  output  16  IR samples between the last two beats.
REQ-014 Port Interval_Valid  output  1  one-cycle pulse, coincident with Beat when Beat_Interval has been updated.

Function
REQ-015 The block SHALL register LED_RED and LED_IR each cycle; red strobe = previous LED_RED=1 and current LED_RED=0 with Enable=1; IR strobe is defined the same way on LED_IR.
REQ-016 On a red strobe the block SHALL take RED_ADC_Value in that cycle as the red sample; the IR strobe SHALL take IR_ADC_Value in the same way; red and IR strobes in the same cycle SHALL both be processed.
REQ-017 The FSM SHALL have states IDLE, FILL and PUBLISH; IDLE->FILL when Enable=1; FILL->PUBLISH on the IR strobe that makes the IR window count equal WINDOW; PUBLISH->FILL unconditionally after one cycle; any state->IDLE when Enable=0.
REQ-018 Per channel, max/min trackers (init max=0, min=255) SHALL update on every strobe of that channel in FILL or PUBLISH.
REQ-019 The closing IR sample, and any red sample in the same cycle, SHALL be included in the closing window.
REQ-020 At window close, the block SHALL register AC = max-min and DC = (max+min)>>1, using a 9-bit sum.
REQ-021 At window close, the trackers and the window count SHALL be reinitialised for the next window.
REQ-022 Strobes in PUBLISH SHALL go into the new window; no sample SHALL be dropped.
REQ-023 If a channel received no sample in a window, that channel's AC and DC outputs SHALL hold their previous values.
REQ-024 Stats_Valid SHALL be 1 for exactly the PUBLISH cycle, one cycle after the closing strobe.
REQ-025 Beat threshold THR SHALL be the registered IR_DC, or 128 before the first window completes.
REQ-026 The high level THR+HYST SHALL saturate at 255 and the low level THR-HYST SHALL floor at 0.
REQ-027 The beat detector SHALL have states LOW and HIGH, starting in LOW.
REQ-028 On an IR strobe in LOW with sample >= THR+HYST, the detector SHALL go to HIGH and pulse Beat in the following cycle.
REQ-029 On an IR strobe in HIGH with sample <= THR-HYST, the detector SHALL go to LOW with no pulse.
REQ-030 The interval counter SHALL increment on each IR strobe, saturating at 65535.
REQ-031 On a beat strobe the counter SHALL be loaded with 1; that strobe SHALL be counted as the first sample of the new interval.
REQ-032 On a beat, Beat_Interval SHALL be loaded with the pre-load counter value, except on the first beat after entering FILL.
REQ-033 Interval_Valid SHALL pulse with Beat only when Beat_Interval was loaded.
REQ-034 Entering IDLE SHALL clear the trackers, window count, interval counter, first-beat flag and beat state (LOW).
REQ-035 Entering IDLE SHALL leave the AC/DC outputs and Beat_Interval holding their values.
REQ-036 Strobes SHALL be ignored while Enable=0, including a falling LED edge in the cycle Enable drops.

Reset
REQ-037 While rst_n=0, all outputs and pulses SHALL be 0.
REQ-038 While rst_n=0, the FSM SHALL be IDLE, the beat detector LOW, THR=128, trackers at max=0/min=255, all counters 0, and the LED edge registers 0.
REQ-039 Reset asserted mid-window SHALL discard the partial window with no Stats_Valid pulse; operation SHALL restart cleanly after rst_n rises.

Verification
REQ-040 WINDOW=4, alternate red/IR phases; red samples 50,90,70,60; IR 100,180,140,120 -> one Stats_Valid pulse; RED_AC=40, RED_DC=70, IR_AC=80, IR_DC=140.
REQ-041 Samples max=255, min=254 -> AC=1, DC=254 (no 8-bit overflow of the sum).
REQ-042 THR=128, HYST=8; IR sequence 130,136,150,119,120,137 -> Beat on the 136 and 137 samples only; Interval_Valid with Beat_Interval=4 on the second beat only.
REQ-043 Red and IR falling edges in the same cycle, repeated for the whole window -> both channels' statistics correct; the window closes after exactly WINDOW pairs.
REQ-044 Enable dropped after 2 of 4 samples, then raised -> no Stats_Valid; the next Stats_Valid reflects only post-re-enable samples; prior outputs hold meanwhile.
REQ-045 rst_n pulsed low asynchronously mid-window and mid-HIGH -> outputs 0 immediately; the first later beat gives Interval_Valid=0.

Source files
------------

// File: rtl/ppg_window_stats_if.sv
// LED-controller side of the PPG window statistics block.
// The controller drives the phase flags and held ADC samples; the block returns
// window statistics and beat information.
interface ppg_window_stats_if;
   logic        Enable;
   logic        LED_RED;
   logic        LED_IR;
   logic [7:0]  RED_ADC_Value;
   logic [7:0]  IR_ADC_Value;
   logic [7:0]  RED_AC;
   logic [7:0]  RED_DC;
   logic [7:0]  IR_AC;
   logic [7:0]  IR_DC;
   logic        Stats_Valid;
   logic        Beat;
   logic [15:0] Beat_Interval;
   logic        Interval_Valid;

   modport master (
      output Enable, LED_RED, LED_IR, RED_ADC_Value, IR_ADC_Value,
      input  RED_AC, RED_DC, IR_AC, IR_DC, Stats_Valid, Beat, Beat_Interval, Interval_Valid
   );

   modport slave (
      input  Enable, LED_RED, LED_IR, RED_ADC_Value, IR_ADC_Value,
      output RED_AC, RED_DC, IR_AC, IR_DC, Stats_Valid, Beat, Beat_Interval, Interval_Valid
   );
endinterface

// File: rtl/ppg_window_stats.sv
// PPG window statistics: per-window AC/DC of red and IR samples plus an IR
// beat detector with hysteresis and beat-to-beat interval measurement.
module ppg_window_stats #(
   parameter int unsigned WINDOW = 100,
   parameter int unsigned HYST   = 8
) (
   input logic               CLK,
   input logic               rst_n,
   ppg_window_stats_if.slave ppg
);

   typedef enum logic [1:0] {StIdle, StFill, StPublish} state_e;

   state_e      state_q, state_d;
   logic        led_red_q, led_ir_q;
   logic        red_stb, ir_stb, win_close;
   logic [9:0]  win_cnt_q, win_cnt_d;
   logic [7:0]  red_max_q, red_max_d, red_min_q, red_min_d;
   logic [7:0]  ir_max_q, ir_max_d, ir_min_q, ir_min_d;
   logic        red_seen_q, red_seen_d;
   logic [7:0]  red_max_upd, red_min_upd, ir_max_upd, ir_min_upd;
   logic        red_seen_upd;
   logic [8:0]  red_sum, ir_sum;
   logic [7:0]  red_ac_q, red_ac_d, red_dc_q, red_dc_d;
   logic [7:0]  ir_ac_q, ir_ac_d, ir_dc_q, ir_dc_d;
   logic [7:0]  thr_q, thr_d, thr_hi, thr_lo;
   logic        beat_hi_q, beat_hi_d, beat_q, beat_d;
   logic        ivl_valid_q, ivl_valid_d, beat_seen_q, beat_seen_d;
   logic [15:0] ivl_cnt_q, ivl_cnt_d, beat_ivl_q, beat_ivl_d;

   // LED phase edge registers, sampled every cycle regardless of Enable
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         led_red_q <= 1'b0;
         led_ir_q  <= 1'b0;
      end else begin
         led_red_q <= ppg.LED_RED;
         led_ir_q  <= ppg.LED_IR;
      end
   end

   // Falling phase edge marks a fresh sample; ignored outside an active window
   assign red_stb   = led_red_q & ~ppg.LED_RED & ppg.Enable & (state_q != StIdle);
   assign ir_stb    = led_ir_q & ~ppg.LED_IR & ppg.Enable & (state_q != StIdle);
   assign win_close = ir_stb && ((32'(win_cnt_q) + 32'd1) == WINDOW);

   // Trackers including the sample arriving this cycle
   assign red_max_upd  = (red_stb && (ppg.RED_ADC_Value > red_max_q)) ? ppg.RED_ADC_Value
                                                                      : red_max_q;
   assign red_min_upd  = (red_stb && (ppg.RED_ADC_Value < red_min_q)) ? ppg.RED_ADC_Value
                                                                      : red_min_q;
   assign ir_max_upd   = (ir_stb && (ppg.IR_ADC_Value > ir_max_q)) ? ppg.IR_ADC_Value : ir_max_q;
   assign ir_min_upd   = (ir_stb && (ppg.IR_ADC_Value < ir_min_q)) ? ppg.IR_ADC_Value : ir_min_q;
   assign red_seen_upd = red_seen_q | red_stb;
   assign red_sum      = {1'b0, red_max_upd} + {1'b0, red_min_upd};
   assign ir_sum       = {1'b0, ir_max_upd} + {1'b0, ir_min_upd};

   // Hysteresis levels, clamped to the 8-bit code range
   always_comb begin
      thr_hi = 8'd255;
      if ((32'(thr_q) + HYST) <= 32'd255) thr_hi = 8'(32'(thr_q) + HYST);
      thr_lo = 8'd0;
      if (32'(thr_q) >= HYST) thr_lo = 8'(32'(thr_q) - HYST);
   end

   // Window FSM state register
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Window FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (ppg.Enable) state_d = StFill;
         StFill: begin
            if (!ppg.Enable)   state_d = StIdle;
            else if (win_close) state_d = StPublish;
         end
         StPublish: state_d = ppg.Enable ? StFill : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Window FSM outputs
   always_comb begin
      ppg.Stats_Valid = (state_q == StPublish);
   end

   // Datapath next state: trackers, window close, beat detector, interval counter
   always_comb begin
      win_cnt_d   = win_cnt_q;
      red_max_d   = red_max_q;
      red_min_d   = red_min_q;
      ir_max_d    = ir_max_q;
      ir_min_d    = ir_min_q;
      red_seen_d  = red_seen_q;
      red_ac_d    = red_ac_q;
      red_dc_d    = red_dc_q;
      ir_ac_d     = ir_ac_q;
      ir_dc_d     = ir_dc_q;
      thr_d       = thr_q;
      beat_hi_d   = beat_hi_q;
      beat_seen_d = beat_seen_q;
      ivl_cnt_d   = ivl_cnt_q;
      beat_ivl_d  = beat_ivl_q;
      beat_d      = 1'b0;
      ivl_valid_d = 1'b0;
      if (state_q == StIdle) begin
         // Published values and THR survive; everything per-session restarts
         win_cnt_d   = '0;
         red_max_d   = '0;
         red_min_d   = '1;
         ir_max_d    = '0;
         ir_min_d    = '1;
         red_seen_d  = 1'b0;
         ivl_cnt_d   = '0;
         beat_seen_d = 1'b0;
         beat_hi_d   = 1'b0;
      end else begin
         red_max_d  = red_max_upd;
         red_min_d  = red_min_upd;
         ir_max_d   = ir_max_upd;
         ir_min_d   = ir_min_upd;
         red_seen_d = red_seen_upd;
         if (ir_stb) win_cnt_d = win_cnt_q + 10'd1;
         if (win_close) begin
            if (red_seen_upd) begin
               red_ac_d = red_max_upd - red_min_upd;
               red_dc_d = red_sum[8:1];
            end
            ir_ac_d    = ir_max_upd - ir_min_upd;
            ir_dc_d    = ir_sum[8:1];
            thr_d      = ir_sum[8:1];
            win_cnt_d  = '0;
            red_max_d  = '0;
            red_min_d  = '1;
            ir_max_d   = '0;
            ir_min_d   = '1;
            red_seen_d = 1'b0;
         end
         if (ir_stb) begin
            if (!beat_hi_q && (ppg.IR_ADC_Value >= thr_hi)) begin
               beat_hi_d   = 1'b1;
               beat_d      = 1'b1;
               beat_seen_d = 1'b1;
               // The beat sample opens the next interval
               ivl_cnt_d   = 16'd1;
               if (beat_seen_q) begin
                  beat_ivl_d  = ivl_cnt_q;
                  ivl_valid_d = 1'b1;
               end
            end else begin
               if (ivl_cnt_q != 16'hFFFF) ivl_cnt_d = ivl_cnt_q + 16'd1;
               if (beat_hi_q && (ppg.IR_ADC_Value <= thr_lo)) beat_hi_d = 1'b0;
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt_q   <= '0;
         red_max_q   <= '0;
         red_min_q   <= '1;
         ir_max_q    <= '0;
         ir_min_q    <= '1;
         red_seen_q  <= 1'b0;
         red_ac_q    <= '0;
         red_dc_q    <= '0;
         ir_ac_q     <= '0;
         ir_dc_q     <= '0;
         thr_q       <= 8'd128;
         beat_hi_q   <= 1'b0;
         beat_seen_q <= 1'b0;
         ivl_cnt_q   <= '0;
         beat_ivl_q  <= '0;
         beat_q      <= 1'b0;
         ivl_valid_q <= 1'b0;
      end else begin
         win_cnt_q   <= win_cnt_d;
         red_max_q   <= red_max_d;
         red_min_q   <= red_min_d;
         ir_max_q    <= ir_max_d;
         ir_min_q    <= ir_min_d;
         red_seen_q  <= red_seen_d;
         red_ac_q    <= red_ac_d;
         red_dc_q    <= red_dc_d;
         ir_ac_q     <= ir_ac_d;
         ir_dc_q     <= ir_dc_d;
         thr_q       <= thr_d;
         beat_hi_q   <= beat_hi_d;
         beat_seen_q <= beat_seen_d;
         ivl_cnt_q   <= ivl_cnt_d;
         beat_ivl_q  <= beat_ivl_d;
         beat_q      <= beat_d;
         ivl_valid_q <= ivl_valid_d;
      end
   end

   assign ppg.RED_AC         = red_ac_q;
   assign ppg.RED_DC         = red_dc_q;
   assign ppg.IR_AC          = ir_ac_q;
   assign ppg.IR_DC          = ir_dc_q;
   assign ppg.Beat           = beat_q;
   assign ppg.Beat_Interval  = beat_ivl_q;
   assign ppg.Interval_Valid = ivl_valid_q;

endmodule

// File: tb/tb_ppg_window_stats.sv
// Bench for ppg_window_stats: two instances (WINDOW=4 and WINDOW=8) share one
// stimulus stream; a window-level model predicts every output each cycle.
module tb_ppg_window_stats;
   localparam int HYST = 8;

   logic       CLK = 1'b0;
   logic       rst_n;
   logic       en, lr, li;
   logic [7:0] rv, iv;

   always #5 CLK = ~CLK;

   ppg_window_stats_if bus4 ();
   ppg_window_stats_if bus8 ();

   assign bus4.Enable        = en;
   assign bus4.LED_RED       = lr;
   assign bus4.LED_IR        = li;
   assign bus4.RED_ADC_Value = rv;
   assign bus4.IR_ADC_Value  = iv;
   assign bus8.Enable        = en;
   assign bus8.LED_RED       = lr;
   assign bus8.LED_IR        = li;
   assign bus8.RED_ADC_Value = rv;
   assign bus8.IR_ADC_Value  = iv;

   ppg_window_stats #(.WINDOW(4), .HYST(HYST)) u_dut4 (.CLK(CLK), .rst_n(rst_n), .ppg(bus4));
   ppg_window_stats #(.WINDOW(8), .HYST(HYST)) u_dut8 (.CLK(CLK), .rst_n(rst_n), .ppg(bus8));

   int checks = 0;
   int errors = 0;
   bit run = 0;
   int win [2] = '{4, 8};

   // Model state per instance: running extremes and counts of the open window
   int m_rmax [2], m_rmin [2], m_rn [2], m_imax [2], m_imin [2], m_in [2];
   int m_thr [2], m_ivl [2];
   bit m_hi [2], m_seen [2];
   int e_rac [2], e_rdc [2], e_iac [2], e_idc [2], e_bi [2];
   bit e_sv [2], e_bt [2], e_iv [2];
   bit p_en, p_lr, p_li;

   task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (W=%0d): got %0d, expected %0d", name, win[inst], act, exp);
      end
   endtask

   function automatic void clear_window(int i);
      m_rmax[i] = 0; m_rmin[i] = 255; m_rn[i] = 0;
      m_imax[i] = 0; m_imin[i] = 255; m_in[i] = 0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         clear_window(i);
         m_thr[i] = 128; m_ivl[i] = 0; m_hi[i] = 0; m_seen[i] = 0;
         e_rac[i] = 0; e_rdc[i] = 0; e_iac[i] = 0; e_idc[i] = 0; e_bi[i] = 0;
         e_sv[i] = 0; e_bt[i] = 0; e_iv[i] = 0;
      end
      p_en = 0; p_lr = 0; p_li = 0;
   endfunction

   // One clock edge: the block is active this cycle iff Enable was 1 last cycle
   function automatic void model_step();
      bit rs, is;
      int hl, ll;
      rs = p_lr && !lr && en;
      is = p_li && !li && en;
      for (int i = 0; i < 2; i++) begin
         e_sv[i] = 0; e_bt[i] = 0; e_iv[i] = 0;
         if (!p_en) begin
            clear_window(i);
            m_ivl[i] = 0; m_hi[i] = 0; m_seen[i] = 0;
         end else begin
            if (rs) begin
               m_rn[i]++;
               if (int'(rv) > m_rmax[i]) m_rmax[i] = int'(rv);
               if (int'(rv) < m_rmin[i]) m_rmin[i] = int'(rv);
            end
            if (is) begin
               hl = m_thr[i] + HYST; if (hl > 255) hl = 255;
               ll = m_thr[i] - HYST; if (ll < 0) ll = 0;
               if (!m_hi[i] && int'(iv) >= hl) begin
                  e_bt[i] = 1;
                  if (m_seen[i]) begin e_iv[i] = 1; e_bi[i] = m_ivl[i]; end
                  m_seen[i] = 1; m_hi[i] = 1; m_ivl[i] = 1;
               end else begin
                  if (m_ivl[i] < 65535) m_ivl[i]++;
                  if (m_hi[i] && int'(iv) <= ll) m_hi[i] = 0;
               end
               m_in[i]++;
               if (int'(iv) > m_imax[i]) m_imax[i] = int'(iv);
               if (int'(iv) < m_imin[i]) m_imin[i] = int'(iv);
               if (m_in[i] == win[i]) begin
                  if (m_rn[i] > 0) begin
                     e_rac[i] = m_rmax[i] - m_rmin[i];
                     e_rdc[i] = (m_rmax[i] + m_rmin[i]) / 2;
                  end
                  e_iac[i] = m_imax[i] - m_imin[i];
                  e_idc[i] = (m_imax[i] + m_imin[i]) / 2;
                  m_thr[i] = e_idc[i];
                  e_sv[i] = 1;
                  clear_window(i);
               end
            end
         end
      end
      p_en = en; p_lr = lr; p_li = li;
   endfunction

   task automatic cmp(int i, logic [7:0] rac, logic [7:0] rdc, logic [7:0] iac,
                      logic [7:0] idc, logic sv, logic bt, logic ivv, logic [15:0] bi);
      chk("RED_AC", i, {24'd0, rac}, e_rac[i]);
      chk("RED_DC", i, {24'd0, rdc}, e_rdc[i]);
      chk("IR_AC", i, {24'd0, iac}, e_iac[i]);
      chk("IR_DC", i, {24'd0, idc}, e_idc[i]);
      chk("Stats_Valid", i, {31'd0, sv}, {31'd0, e_sv[i]});
      chk("Beat", i, {31'd0, bt}, {31'd0, e_bt[i]});
      chk("Interval_Valid", i, {31'd0, ivv}, {31'd0, e_iv[i]});
      chk("Beat_Interval", i, {16'd0, bi}, e_bi[i]);
   endtask

   // Compare process: every negedge, both instances against the model
   always @(negedge CLK) begin
      if (run) begin
         cmp(0, bus4.RED_AC, bus4.RED_DC, bus4.IR_AC, bus4.IR_DC, bus4.Stats_Valid,
             bus4.Beat, bus4.Interval_Valid, bus4.Beat_Interval);
         cmp(1, bus8.RED_AC, bus8.RED_DC, bus8.IR_AC, bus8.IR_DC, bus8.Stats_Valid,
             bus8.Beat, bus8.Interval_Valid, bus8.Beat_Interval);
      end
   end

   // Inputs are already set; predict the coming edge, then move to negedge+1
   task automatic step();
      if (!rst_n) model_reset();
      else        model_step();
      @(negedge CLK);
      #1;
   endtask

   task automatic red(int v);
      rv = 8'(v); lr = 1; step(); lr = 0; step();
   endtask

   task automatic ir(int v);
      iv = 8'(v); li = 1; step(); li = 0; step();
   endtask

   task automatic pair(int r, int i);
      rv = 8'(r); iv = 8'(i); lr = 1; li = 1; step(); lr = 0; li = 0; step();
   endtask

   task automatic zero_pins(string tag);
      chk({tag, "_RED_AC"}, 0, {24'd0, bus4.RED_AC}, 0);
      chk({tag, "_IR_DC"}, 0, {24'd0, bus4.IR_DC}, 0);
      chk({tag, "_RED_DC"}, 1, {24'd0, bus8.RED_DC}, 0);
      chk({tag, "_IR_AC"}, 1, {24'd0, bus8.IR_AC}, 0);
      chk({tag, "_Beat_Interval"}, 1, {16'd0, bus8.Beat_Interval}, 0);
      chk({tag, "_Beat"}, 1, {31'd0, bus8.Beat}, 0);
      chk({tag, "_Stats_Valid"}, 0, {31'd0, bus4.Stats_Valid}, 0);
   endtask

   // Asynchronous reset asserted away from any clock edge
   task automatic do_reset();
      #2;
      rst_n = 0;
      #1;
      zero_pins("async_rst");
      en = 0; lr = 0; li = 0;
      step(); step();
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; en = 0; lr = 0; li = 0; rv = 0; iv = 0;
      model_reset();
      run = 1;
      @(negedge CLK);
      #1;
      zero_pins("reset");
      step(); step();
      rst_n = 1;

      // Alternating phases, WINDOW=4
      en = 1; step();
      red(50); ir(100); red(90); ir(180); red(70); ir(140); red(60); ir(120);
      chk("alt_sv", 0, {31'd0, bus4.Stats_Valid}, 1);
      chk("alt_RED_AC", 0, {24'd0, bus4.RED_AC}, 40);
      chk("alt_RED_DC", 0, {24'd0, bus4.RED_DC}, 70);
      chk("alt_IR_AC", 0, {24'd0, bus4.IR_AC}, 80);
      chk("alt_IR_DC", 0, {24'd0, bus4.IR_DC}, 140);
      chk("alt_sv_w8", 1, {31'd0, bus8.Stats_Valid}, 0);

      // Simultaneous edges; 255/254 must not overflow the sum
      pair(255, 255); pair(254, 254); pair(255, 255); pair(254, 254);
      chk("ovf_sv", 0, {31'd0, bus4.Stats_Valid}, 1);
      chk("ovf_RED_AC", 0, {24'd0, bus4.RED_AC}, 1);
      chk("ovf_RED_DC", 0, {24'd0, bus4.RED_DC}, 254);
      chk("ovf_IR_AC", 0, {24'd0, bus4.IR_AC}, 1);
      chk("ovf_IR_DC", 0, {24'd0, bus4.IR_DC}, 254);
      chk("w8_RED_AC", 1, {24'd0, bus8.RED_AC}, 205);
      chk("w8_RED_DC", 1, {24'd0, bus8.RED_DC}, 152);
      chk("w8_IR_AC", 1, {24'd0, bus8.IR_AC}, 155);
      chk("w8_IR_DC", 1, {24'd0, bus8.IR_DC}, 177);
      pair(10, 200); pair(30, 220); pair(20, 210);
      chk("pair_early_sv", 0, {31'd0, bus4.Stats_Valid}, 0);
      pair(40, 205);
      chk("pair_sv", 0, {31'd0, bus4.Stats_Valid}, 1);
      chk("pair_RED_AC", 0, {24'd0, bus4.RED_AC}, 30);
      chk("pair_RED_DC", 0, {24'd0, bus4.RED_DC}, 25);
      chk("pair_IR_AC", 0, {24'd0, bus4.IR_AC}, 20);
      chk("pair_IR_DC", 0, {24'd0, bus4.IR_DC}, 210);

      // Enable dropped mid-window, falling edge in the drop cycle
      pair(5, 250); pair(250, 5);
      lr = 1; li = 1; step();
      en = 0; lr = 0; li = 0; step(); step(); step();
      chk("hold_RED_AC", 0, {24'd0, bus4.RED_AC}, 30);
      chk("hold_IR_DC", 0, {24'd0, bus4.IR_DC}, 210);
      en = 1; step();
      pair(60, 160); pair(100, 170); pair(70, 180); pair(80, 150);
      chk("reen_sv", 0, {31'd0, bus4.Stats_Valid}, 1);
      chk("reen_RED_AC", 0, {24'd0, bus4.RED_AC}, 40);
      chk("reen_RED_DC", 0, {24'd0, bus4.RED_DC}, 80);
      chk("reen_IR_AC", 0, {24'd0, bus4.IR_AC}, 30);
      chk("reen_IR_DC", 0, {24'd0, bus4.IR_DC}, 165);

      // Beat detector from THR=128, WINDOW=8 instance
      do_reset();
      en = 1; step();
      ir(130); ir(136);
      chk("beat1", 1, {31'd0, bus8.Beat}, 1);
      chk("beat1_iv", 1, {31'd0, bus8.Interval_Valid}, 0);
      ir(150);
      chk("no_beat_150", 1, {31'd0, bus8.Beat}, 0);
      ir(119); ir(120); ir(137);
      chk("beat2", 1, {31'd0, bus8.Beat}, 1);
      chk("beat2_iv", 1, {31'd0, bus8.Interval_Valid}, 1);
      chk("beat2_interval", 1, {16'd0, bus8.Beat_Interval}, 4);

      // Reset while HIGH and mid-window; first later beat has no interval
      do_reset();
      en = 1; step();
      ir(200);
      chk("post_rst_beat", 1, {31'd0, bus8.Beat}, 1);
      chk("post_rst_iv", 1, {31'd0, bus8.Interval_Valid}, 0);
      chk("post_rst_iv4", 0, {31'd0, bus4.Interval_Valid}, 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int op;
         op = $urandom_range(0, 9);
         if (n == 200) begin
            do_reset();
            en = 1; step();
         end
         case (op)
            0, 1, 2: pair($urandom_range(0, 255), $urandom_range(0, 255));
            3, 4:    red($urandom_range(0, 255));
            5, 6:    ir($urandom_range(0, 255));
            7:       step();
            8: begin
               en = 0;
               repeat ($urandom_range(1, 3)) begin
                  lr = 1'($urandom_range(0, 1)); li = 1'($urandom_range(0, 1));
                  step();
               end
               en = 1; step();
            end
            default: begin
               lr = 1'($urandom_range(0, 1)); li = 1'($urandom_range(0, 1));
               rv = 8'($urandom_range(0, 255)); iv = 8'($urandom_range(0, 255));
               step();
            end
         endcase
      end

      en = 0; lr = 0; li = 0;
      step(); step();
      run = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
